// File: rtl/sipo_div_rx.sv
// ----------------------------------------------------------------------------
// sipo_div_rx
// Serial-in / parallel-out receiver for a clock-divided serial stream.
// The upstream stage holds each bit on ser_in for DIV clk cycles, MSB first,
// and pulses sync on the first clk cycle of the MSB bit period. This block
// samples each bit mid-period, reassembles WIDTH-bit words back-to-back and
// presents them with a valid/ready handshake. A word that completes while
// the previous one is still unconsumed is dropped and flagged on overrun.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active high
//   ser_in     : serial data line
//   sync       : one-cycle strobe on the first cycle of the MSB bit period
//   data_ready : consumer accept
//   data_out   : reassembled word (registered)
//   data_valid : data_out holds an unconsumed word (registered)
//   overrun    : sticky, a completed word was dropped (registered)
// ----------------------------------------------------------------------------
module sipo_div_rx #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             sync,
   input  logic             data_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             overrun
);

   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(DIV / 2);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e             state_q,   state_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]   shift_q,   shift_d;
   logic [WIDTH-1:0]   data_q,    data_d;
   logic               valid_q,   valid_d;
   logic               ovr_q,     ovr_d;

   // Effective view of the current cycle: sync overrides the stored state,
   // counters and partial word so the sync cycle itself is relative cycle 0.
   state_e             cur_state;
   logic [DIV_W-1:0]   cur_div;
   logic [BIT_W-1:0]   cur_bit;
   logic [WIDTH-1:0]   cur_shift;

   logic               sample;
   logic               word_done;
   logic               transfer;
   logic [WIDTH-1:0]   shifted;

   // Next-state and datapath
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;

      cur_state = state_q;
      cur_div   = div_cnt_q;
      cur_bit   = bit_cnt_q;
      cur_shift = shift_q;

      if (sync) begin
         cur_state = SHIFT;
         cur_div   = '0;
         cur_bit   = '0;
         cur_shift = '0;
      end

      // Mid-bit sample; never in the sync cycle itself since DIV/2 >= 1
      sample    = (cur_state == SHIFT) && (cur_div == SAMPLE_AT);
      word_done = sample && (cur_bit == BIT_LAST);
      transfer  = valid_q && data_ready;
      shifted   = {cur_shift[WIDTH-2:0], ser_in};

      state_d   = cur_state;
      bit_cnt_d = cur_bit;
      shift_d   = cur_shift;

      if (cur_state == SHIFT) begin
         div_cnt_d = (cur_div == DIV_LAST) ? '0 : cur_div + DIV_W'(1);
      end else begin
         div_cnt_d = cur_div;
      end

      if (sample) begin
         shift_d   = shifted;
         bit_cnt_d = word_done ? '0 : cur_bit + BIT_W'(1);
      end

      // Output handshake: a completed word loads when the holding register
      // is empty or being drained at this edge, otherwise it is dropped.
      if (word_done) begin
         if (!valid_q || transfer) begin
            data_d  = shifted;
            valid_d = 1'b1;
         end else begin
            ovr_d   = 1'b1;
         end
      end else if (transfer) begin
         valid_d = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign overrun    = ovr_q;

endmodule
